order_issuer: RTL and testbench

ORDER_ISSUER -- requirements
Module: order_issuer

---
 rtl/ob_pkg.sv | 48 ++++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/order_issuer.sv | 234 +++++++++++++++++++++++
 tb/tb_order_issuer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// ob_pkg: shared definitions for the order issuer.
//   - default parameter widths for the command path
//   - in_type command encoding (cmd_type_e)
//   - op_flag encodings driven towards the orderbook
//   - helpers mapping a command to its op_flag and its reject rule
package ob_pkg;

    localparam int PRICE_WIDTH_DEF = 8;
    localparam int PTR_QUEUE_DEF   = 10;
    localparam int PTR_WIDTH_DEF   = 6;
    localparam int DATA_SIZE_DEF   = 64;
    localparam int DEPTH_DEF       = 8;
    localparam int QTY_WIDTH       = 8;

    typedef enum logic [1:0] {
        CMD_ADD    = 2'd0,
        CMD_MATCH  = 2'd1,
        CMD_REMOVE = 2'd2,
        CMD_MODIFY = 2'd3
    } cmd_type_e;

    localparam logic [2:0] OP_NONE   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b100;
    localparam logic [2:0] OP_MATCH  = 3'b101;
    localparam logic [2:0] OP_REMOVE = 3'b110;
    localparam logic [2:0] OP_MODIFY = 3'b111;

    function automatic logic [2:0] op_flag_of(input cmd_type_e t);
        logic [2:0] f;
        unique case (t)
            CMD_ADD:    f = OP_ADD;
            CMD_MATCH:  f = OP_MATCH;
            CMD_REMOVE: f = OP_REMOVE;
            CMD_MODIFY: f = OP_MODIFY;
        endcase
        return f;
    endfunction

    // A remove/modify must name a real queue (id 0 is reserved) and a match
    // must pop at least one entry; anything else would be a no-op downstream.
    function automatic logic cmd_rejected(input cmd_type_e t,
                                          input logic      q_index_zero,
                                          input logic      qty_zero);
        return ((t == CMD_REMOVE || t == CMD_MODIFY) && q_index_zero) ||
               (t == CMD_MATCH && qty_zero);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command FIFO, DEPTH entries (power of two).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head entry is presented combinationally on rd_data.
//   clk, reset_n   : clock, asynchronous active-low reset (clears pointers)
//   push, wr_data  : write request and entry (ignored when full)
//   pop, rd_data   : read request (ignored when empty) and current head
//   full, empty    : occupancy flags
//   count          : number of stored entries
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/order_issuer.sv
// order_issuer: buffers orderbook commands and issues them one op per cycle.
//   clk, reset_n           : sole clock, asynchronous active-low reset
//   in_valid / in_ready    : command handshake (in_ready = FIFO not full)
//   in_type, in_side, in_price, in_q_index, in_index, in_data, in_qty
//                          : command fields (in_qty = match pop count)
//   ob_stall               : orderbook busy, no op issued while high
//   op_flag, side, price, op_q_index, op_index, op_data
//                          : registered op towards the orderbook (000 = idle)
//   reject_cnt             : saturating count of rejected commands
//   issue_cnt              : wrapping count of issued ops
//
// state | meaning
// IDLE  | waiting for a buffered command and ob_stall low
// ISSUE | pop the FIFO head and drive its op for one cycle
// MATCH | repeat match pulses on unstalled cycles until qty is used up
module order_issuer
    import ob_pkg::*;
#(
    parameter int PRICE_WIDTH = PRICE_WIDTH_DEF,
    parameter int PTR_QUEUE   = PTR_QUEUE_DEF,
    parameter int PTR_WIDTH   = PTR_WIDTH_DEF,
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_type,
    input  logic                   in_side,
    input  logic [PRICE_WIDTH-1:0] in_price,
    input  logic [PTR_QUEUE-1:0]   in_q_index,
    input  logic [PTR_WIDTH-1:0]   in_index,
    input  logic [DATA_SIZE-1:0]   in_data,
    input  logic [7:0]             in_qty,
    input  logic                   ob_stall,
    output logic [2:0]             op_flag,
    output logic                   side,
    output logic [PRICE_WIDTH-1:0] price,
    output logic [PTR_QUEUE-1:0]   op_q_index,
    output logic [PTR_WIDTH-1:0]   op_index,
    output logic [DATA_SIZE-1:0]   op_data,
    output logic [15:0]            reject_cnt,
    output logic [31:0]            issue_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 2 + 1 + PRICE_WIDTH + PTR_QUEUE + PTR_WIDTH +
                             DATA_SIZE + QTY_WIDTH;
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_MATCH = 2'd2;

    // Command acceptance and FIFO
    cmd_type_e          in_cmd;
    logic               accept;
    logic               rejected;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW:0]        fifo_count;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    logic [1:0]             hd_type;
    cmd_type_e              hd_cmd;
    logic                   hd_side;
    logic [PRICE_WIDTH-1:0] hd_price;
    logic [PTR_QUEUE-1:0]   hd_q_index;
    logic [PTR_WIDTH-1:0]   hd_index;
    logic [DATA_SIZE-1:0]   hd_data;
    logic [7:0]             hd_qty;

    assign in_cmd    = cmd_type_e'(in_type);
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign rejected  = cmd_rejected(in_cmd, in_q_index == '0, in_qty == 8'd0);
    assign fifo_push = accept && !rejected;
    assign wr_entry  = {in_type, in_side, in_price, in_q_index, in_index,
                        in_data, in_qty};

    assign {hd_type, hd_side, hd_price, hd_q_index, hd_index, hd_data,
            hd_qty} = rd_entry;
    assign hd_cmd = cmd_type_e'(hd_type);

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM, match burst state and registered op outputs
    logic [1:0]             state_q, state_d;
    logic [7:0]             remain_q, remain_d;
    logic                   m_side_q, m_side_d;
    logic [PRICE_WIDTH-1:0] m_price_q, m_price_d;

    logic [2:0]             op_flag_q, op_flag_d;
    logic                   side_q, side_d;
    logic [PRICE_WIDTH-1:0] price_q, price_d;
    logic [PTR_QUEUE-1:0]   op_q_index_q, op_q_index_d;
    logic [PTR_WIDTH-1:0]   op_index_q, op_index_d;
    logic [DATA_SIZE-1:0]   op_data_q, op_data_d;
    logic [15:0]            reject_cnt_q, reject_cnt_d;
    logic [31:0]            issue_cnt_q, issue_cnt_d;

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        m_side_d     = m_side_q;
        m_price_d    = m_price_q;
        fifo_pop     = 1'b0;
        op_flag_d    = OP_NONE;
        side_d       = 1'b0;
        price_d      = '0;
        op_q_index_d = '0;
        op_index_d   = '0;
        op_data_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !ob_stall) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ob_stall || fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    fifo_pop  = 1'b1;
                    op_flag_d = op_flag_of(hd_cmd);
                    side_d    = hd_side;
                    price_d   = hd_price;
                    unique case (hd_cmd)
                        CMD_ADD: begin
                            op_q_index_d = hd_q_index;
                            op_data_d    = hd_data;
                        end
                        CMD_MATCH: ;
                        CMD_REMOVE, CMD_MODIFY: begin
                            op_q_index_d = hd_q_index;
                            op_index_d   = hd_index;
                            op_data_d    = hd_data;
                        end
                    endcase
                    if (hd_cmd == CMD_MATCH && hd_qty > 8'd1) begin
                        state_d   = ST_MATCH;
                        remain_d  = hd_qty - 8'd1;
                        m_side_d  = hd_side;
                        m_price_d = hd_price;
                    end else if (fifo_count != CNT_ONE) begin
                        // More entries were already waiting before this
                        // cycle's push, so keep issuing back to back. A
                        // command landing in an empty FIFO goes through
                        // IDLE first.
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MATCH: begin
                if (!ob_stall) begin
                    op_flag_d = OP_MATCH;
                    side_d    = m_side_q;
                    price_d   = m_price_q;
                    remain_d  = remain_q - 8'd1;
                    if (remain_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reject_cnt_d = reject_cnt_q;
        if (accept && rejected && reject_cnt_q != 16'hFFFF)
            reject_cnt_d = reject_cnt_q + 16'd1;

        issue_cnt_d = issue_cnt_q;
        if (op_flag_d != OP_NONE)
            issue_cnt_d = issue_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            m_side_q     <= 1'b0;
            m_price_q    <= '0;
            op_flag_q    <= OP_NONE;
            side_q       <= 1'b0;
            price_q      <= '0;
            op_q_index_q <= '0;
            op_index_q   <= '0;
            op_data_q    <= '0;
            reject_cnt_q <= '0;
            issue_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            m_side_q     <= m_side_d;
            m_price_q    <= m_price_d;
            op_flag_q    <= op_flag_d;
            side_q       <= side_d;
            price_q      <= price_d;
            op_q_index_q <= op_q_index_d;
            op_index_q   <= op_index_d;
            op_data_q    <= op_data_d;
            reject_cnt_q <= reject_cnt_d;
            issue_cnt_q  <= issue_cnt_d;
        end
    end

    assign op_flag    = op_flag_q;
    assign side       = side_q;
    assign price      = price_q;
    assign op_q_index = op_q_index_q;
    assign op_index   = op_index_q;
    assign op_data    = op_data_q;
    assign reject_cnt = reject_cnt_q;
    assign issue_cnt  = issue_cnt_q;

endmodule

// File: tb/tb_order_issuer.sv
// Testbench for order_issuer: directed scenarios plus randomized traffic,
// checked against an expected-op queue built from the command rules.
module tb_order_issuer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic        in_side;
    logic [7:0]  in_price;
    logic [9:0]  in_q_index;
    logic [5:0]  in_index;
    logic [63:0] in_data;
    logic [7:0]  in_qty;
    logic        ob_stall;
    logic [2:0]  op_flag;
    logic        side;
    logic [7:0]  price;
    logic [9:0]  op_q_index;
    logic [5:0]  op_index;
    logic [63:0] op_data;
    logic [15:0] reject_cnt;
    logic [31:0] issue_cnt;

    order_issuer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_side    (in_side),
        .in_price   (in_price),
        .in_q_index (in_q_index),
        .in_index   (in_index),
        .in_data    (in_data),
        .in_qty     (in_qty),
        .ob_stall   (ob_stall),
        .op_flag    (op_flag),
        .side       (side),
        .price      (price),
        .op_q_index (op_q_index),
        .op_index   (op_index),
        .op_data    (op_data),
        .reject_cnt (reject_cnt),
        .issue_cnt  (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected op stream {op_flag, side, price, q_index, index, data}
    logic [91:0] exp_q[$];
    logic [31:0] model_iss;
    logic [15:0] model_rej;

    task automatic model_accept(input logic [1:0] ty, input logic sd,
                                input logic [7:0] pr, input logic [9:0] qi,
                                input logic [5:0] ix, input logic [63:0] dt,
                                input logic [7:0] qt);
        case (ty)
            2'd0: exp_q.push_back({3'b100, sd, pr, qi, 6'd0, dt});
            2'd1: begin
                if (qt == 8'd0) begin
                    if (model_rej != 16'hFFFF) model_rej++;
                end else begin
                    for (int k = 0; k < int'(qt); k++)
                        exp_q.push_back({3'b101, sd, pr, 10'd0, 6'd0, 64'd0});
                end
            end
            default: begin
                if (qi == 10'd0) begin
                    if (model_rej != 16'hFFFF) model_rej++;
                end else begin
                    exp_q.push_back({(ty == 2'd2) ? 3'b110 : 3'b111,
                                     sd, pr, qi, ix, dt});
                end
            end
        endcase
    endtask

    always @(posedge clk) begin : monitor
        logic        acc, stall_prev, rst_seen;
        logic [1:0]  c_ty;
        logic        c_sd;
        logic [7:0]  c_pr, c_qt;
        logic [9:0]  c_qi;
        logic [5:0]  c_ix;
        logic [63:0] c_dt;
        rst_seen   = !reset_n;
        acc        = in_valid && in_ready;
        stall_prev = ob_stall;
        c_ty = in_type; c_sd = in_side; c_pr = in_price; c_qi = in_q_index;
        c_ix = in_index; c_dt = in_data; c_qt = in_qty;
        #1;
        if (rst_seen || !reset_n) begin
            exp_q.delete();
            model_iss = '0;
            model_rej = '0;
        end else begin
            if (acc) model_accept(c_ty, c_sd, c_pr, c_qi, c_ix, c_dt, c_qt);
            if (op_flag != 3'b000) begin
                if (stall_prev) check_eq("stall_gap", op_flag, 3'b000);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_op", op_flag, 3'b000);
                end else begin
                    check_eq("op", {op_flag, side, price, op_q_index, op_index, op_data},
                             exp_q.pop_front());
                    model_iss++;
                end
            end
            check_eq("issue_cnt", issue_cnt, model_iss);
            check_eq("reject_cnt", reject_cnt, model_rej);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_type = 2'd0; in_side = 1'b0; in_price = '0;
        in_q_index = '0; in_index = '0; in_data = '0; in_qty = '0;
    endtask

    task automatic send(input logic [1:0] ty, input logic sd, input logic [7:0] pr,
                        input logic [9:0] qi, input logic [5:0] ix,
                        input logic [63:0] dt, input logic [7:0] qt);
        int waited;
        waited = 0;
        in_type = ty; in_side = sd; in_price = pr; in_q_index = qi;
        in_index = ix; in_data = dt; in_qty = qt; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) check_eq("send_timeout", in_ready, 1'b1);
        tick();
        idle_inputs();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || op_flag != 3'b000) && n < 1000) begin
            tick();
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        ob_stall = 1'b0;
        idle_inputs();
        #22;
        check_eq("rst_op_flag", op_flag, 3'b000);
        reset_n = 1'b1;
        tick();
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_issue_cnt", issue_cnt, 32'd0);
        check_eq("rst_reject_cnt", reject_cnt, 16'd0);

        // Add bid, price 42: op appears two edges after acceptance
        send(2'd0, 1'b0, 8'd42, 10'd0, 6'd0, 64'hABCD, 8'd0);
        check_eq("add_lat0", op_flag, 3'b000);
        tick();
        check_eq("add_lat1", op_flag, 3'b000);
        tick();
        check_eq("add_flag", op_flag, 3'b100);
        check_eq("add_side", side, 1'b0);
        check_eq("add_price", price, 8'd42);
        check_eq("add_data", op_data, 64'hABCD);
        check_eq("add_index", op_index, 6'd0);
        check_eq("add_issue_cnt", issue_cnt, 32'd1);
        tick();
        check_eq("add_one_cycle", op_flag, 3'b000);

        // Match ask, price 7, qty 3, stalled during the second pulse
        send(2'd1, 1'b1, 8'd7, 10'd0, 6'd0, 64'd0, 8'd3);
        tick();
        check_eq("m_p0", op_flag, 3'b000);
        tick();
        check_eq("m_p1", op_flag, 3'b101);
        check_eq("m_side", side, 1'b1);
        check_eq("m_price", price, 8'd7);
        ob_stall = 1'b1;
        tick();
        check_eq("m_stall", op_flag, 3'b000);
        ob_stall = 1'b0;
        tick();
        check_eq("m_p2", op_flag, 3'b101);
        tick();
        check_eq("m_p3", op_flag, 3'b101);
        tick();
        check_eq("m_end", op_flag, 3'b000);
        check_eq("m_issue_cnt", issue_cnt, 32'd4);

        // Remove with queue 0 is rejected; a valid remove is issued
        send(2'd2, 1'b0, 8'd0, 10'd0, 6'd0, 64'd0, 8'd0);
        check_eq("rej_cnt", reject_cnt, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rej_no_op", op_flag, 3'b000);
        end
        send(2'd2, 1'b0, 8'd0, 10'd5, 6'd3, 64'd0, 8'd0);
        tick();
        tick();
        check_eq("rm_flag", op_flag, 3'b110);
        check_eq("rm_q_index", op_q_index, 10'd5);
        check_eq("rm_index", op_index, 6'd3);
        tick();

        // Fill the FIFO under stall, then release and drain in order
        ob_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("fill_ready", in_ready, 1'b1);
            send(2'd0, 1'(i), 8'(10 + i), 10'(i + 1), 6'd0, 64'(100 + i), 8'd0);
        end
        check_eq("full_ready", in_ready, 1'b0);
        tick();
        check_eq("full_no_op", op_flag, 3'b000);
        ob_stall = 1'b0;
        send(2'd3, 1'b1, 8'd77, 10'd9, 6'd9, 64'd999, 8'd0);
        wait_drain();
        check_eq("fill_issue_cnt", issue_cnt, 32'd14);

        // Reset in the middle of a 10-pulse match burst
        send(2'd1, 1'b0, 8'd99, 10'd0, 6'd0, 64'd0, 8'd10);
        repeat (5) tick();
        check_eq("burst_p4", op_flag, 3'b101);
        #4;
        reset_n = 1'b0;
        #1;
        check_eq("arst_op_flag", op_flag, 3'b000);
        check_eq("arst_issue_cnt", issue_cnt, 32'd0);
        check_eq("arst_reject_cnt", reject_cnt, 16'd0);
        tick();
        #3;
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_ready", in_ready, 1'b1);
        for (int i = 0; i < 15; i++) begin
            check_eq("post_rst_quiet", op_flag, 3'b000);
            tick();
        end

        // Randomized traffic with random stalls
        for (int i = 0; i < 600; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_type    = 2'($urandom_range(0, 3));
            in_side    = 1'($urandom_range(0, 1));
            in_price   = 8'($urandom);
            in_q_index = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            in_index   = 6'($urandom);
            in_data    = {32'($urandom), 32'($urandom)};
            in_qty     = 8'($urandom_range(0, 4));
            ob_stall   = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle_inputs();
        ob_stall = 1'b0;
        wait_drain();

        // Reject counter saturates
        in_valid = 1'b1; in_type = 2'd2; in_q_index = 10'd0;
        repeat (65540) tick();
        idle_inputs();
        tick();
        check_eq("reject_sat", reject_cnt, 16'hFFFF);
        check_eq("sat_no_ops", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
